// File: rtl/pulse_stretch.sv
// pulse_stretch: turns short event strobes into visible pulses with a guaranteed
// minimum high time (HOLD) and low time (GAP). Events that arrive while a pulse
// is in progress are queued up to MAX_PENDING and replayed in order. When the
// queue is full, further events are dropped and the sticky overflow flag is set.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset (synchronous release expected)
//   event_in  in   event request; each rising edge is one event (synchronous to clk)
//   pulse_out out  stretched pulse (registered)
//   busy      out  high whenever a pulse or its gap is in progress (registered)
//   pending   out  number of queued events not yet emitted (registered)
//   overflow  out  sticky: an event arrived while the queue was full (registered)
module pulse_stretch #(
  parameter int unsigned HOLD         = 50_000_000,  // ns
  parameter int unsigned GAP          = 50_000_000,  // ns
  parameter int unsigned CLOCK_PERIOD = 20,          // ns
  parameter int unsigned MAX_PENDING  = 7,
  localparam int unsigned PEND_W      = $clog2(MAX_PENDING + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              event_in,
  output logic              pulse_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  localparam int unsigned HOLD_CYCLES = HOLD / CLOCK_PERIOD;
  localparam int unsigned GAP_CYCLES  = GAP / CLOCK_PERIOD;
  localparam int unsigned MAX_CYCLES  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W       = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                prev_q, prev_d;
  logic                pulse_q, pulse_d;
  logic                busy_q, busy_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic                overflow_q, overflow_d;

  logic                evt_c;
  logic                gap_end_c;
  logic                consume_c;
  logic                enqueue_c;

  assign evt_c = event_in & ~prev_q;

  // Next-state, queue and output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_d     = event_in;
    pending_d  = pending_q;
    overflow_d = overflow_q;
    gap_end_c  = 1'b0;
    consume_c  = 1'b0;
    enqueue_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (evt_c) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          gap_end_c = 1'b1;
          cnt_d     = '0;
          state_d   = (pending_q != '0 || evt_c) ? S_HOLD : S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // A queued event is consumed first at gap end; a fresh event on that cycle
    // with an empty queue starts the next pulse directly instead of being queued.
    consume_c = gap_end_c && (pending_q != '0);
    if (state_q != S_IDLE && evt_c) begin
      if (pending_q == PEND_MAX) begin
        overflow_d = 1'b1;
      end else if (!(gap_end_c && pending_q == '0)) begin
        enqueue_c = 1'b1;
      end
    end

    if (consume_c && !enqueue_c) begin
      pending_d = pending_q - PEND_W'(1);
    end else if (enqueue_c && !consume_c) begin
      pending_d = pending_q + PEND_W'(1);
    end

    pulse_d = (state_d == S_HOLD);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers; history resets high so a level held across
  // reset release is not seen as an event.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prev_q     <= 1'b1;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Directed bench for pulse_stretch with HOLD=100ns, GAP=60ns, 20ns clock
// (5 hold / 3 gap cycles) and a 3-deep queue.
`timescale 1ns/1ps
module tb_pulse_stretch;

  logic       clk;
  logic       reset_n;
  logic       event_in;
  logic       pulse_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  int n_vec;
  int n_bad;

  pulse_stretch #(
    .HOLD         (100),
    .GAP          (60),
    .CLOCK_PERIOD (20),
    .MAX_PENDING  (3)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .event_in  (event_in),
    .pulse_out (pulse_out),
    .busy      (busy),
    .pending   (pending),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected queue depth for the burst tests, i = cycles after the first strobe's edge.
  function automatic int burst_pend(input int i);
    if (i < 2)  return 0;
    if (i < 4)  return 1;
    if (i < 6)  return 2;
    if (i < 8)  return 3;
    if (i < 16) return 2;
    if (i < 24) return 1;
    return 0;
  endfunction

  // Strobes at offsets 0,2,4,6 (and 8 when extra=1, landing on the gap-end edge
  // while the queue is full). Both variants emit exactly 4 pulses spaced 8 cycles.
  task automatic run_burst(input bit extra, input string tag);
    int rises;
    logic last;
    rises = 0;
    last = 1'b0;
    event_in = 1'b1;
    cyc();
    for (int i = 0; i < 40; i++) begin
      check_eq({tag, "_pulse"}, int'(pulse_out), int'(((i % 8) < 5) && (i < 32)));
      check_eq({tag, "_pend"}, int'(pending), burst_pend(i));
      check_eq({tag, "_ovf"}, int'(overflow), int'(extra && i >= 8));
      if (pulse_out && !last) rises++;
      last = pulse_out;
      event_in = ((i + 1) == 2 || (i + 1) == 4 || (i + 1) == 6 || (extra && (i + 1) == 8));
      cyc();
    end
    check_eq({tag, "_rises"}, rises, 4);
    check_eq({tag, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    int highs;
    n_vec = 0;
    n_bad = 0;
    event_in = 1'b0;
    reset_n = 1'b1;
    #5 reset_n = 1'b0;
    #1;
    check_eq("rst_pulse", int'(pulse_out), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_pend", int'(pending), 0);
    check_eq("rst_ovf", int'(overflow), 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
    cyc();

    // Single strobe: 5 high, 3 gap, then idle.
    event_in = 1'b1;
    cyc();
    event_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_eq("one_pulse", int'(pulse_out), int'(i < 5));
      check_eq("one_busy", int'(busy), int'(i < 8));
      check_eq("one_pend", int'(pending), 0);
      cyc();
    end

    // Long level: exactly one pulse.
    highs = 0;
    event_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (pulse_out) highs++;
    end
    check_eq("level_busy", int'(busy), 0);
    event_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (pulse_out) highs++;
    end
    check_eq("level_highs", highs, 5);

    run_burst(1'b0, "q3");
    run_burst(1'b1, "ovf");

    // Strobe on the gap-end edge with an empty queue: back-to-back pulses.
    event_in = 1'b1;
    cyc();
    for (int i = 0; i < 20; i++) begin
      check_eq("gapend_pulse", int'(pulse_out), int'(i < 5 || (i >= 8 && i < 13)));
      check_eq("gapend_busy", int'(busy), int'(i < 16));
      check_eq("gapend_pend", int'(pending), 0);
      event_in = ((i + 1) == 8);
      cyc();
    end
    check_eq("ovf_sticky", int'(overflow), 1);

    // Reset mid-hold with two queued events, event held high across release.
    event_in = 1'b1;
    cyc();
    event_in = 1'b0;
    cyc();
    event_in = 1'b1;
    cyc();
    event_in = 1'b0;
    cyc();
    event_in = 1'b1;
    cyc();
    check_eq("mid_pulse", int'(pulse_out), 1);
    check_eq("mid_pend", int'(pending), 2);
    reset_n = 1'b0;
    #1;
    check_eq("arst_pulse", int'(pulse_out), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_pend", int'(pending), 0);
    check_eq("arst_ovf", int'(overflow), 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_eq("rel_pulse", int'(pulse_out), 0);
      check_eq("rel_busy", int'(busy), 0);
    end
    event_in = 1'b0;
    cyc();
    event_in = 1'b1;
    cyc();
    check_eq("post_rst_pulse", int'(pulse_out), 1);
    event_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
